// File: rtl/deconv_seq.sv
// deconv_seq: sequential deconvolver, the inverse of the 8x8 `conv` block.
// Given y[0..7] = first 8 samples of x*h and the 8-tap kernel h, recovers
// x[0..7] by forward substitution:
//   x[n] = (y[n] - sum_{k=1..n} h[k]*x[n-k]) / h[0]
// using one multiply-accumulate per cycle and a 4-cycle restoring divider.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   run request, sampled only while idle
//   y_flat  y[i] = y_flat[i*YW +: YW], captured at start
//   h_flat  h[i] = h_flat[i*XW +: XW], captured at start
//   busy    high while a run is in progress
//   done    one-cycle completion pulse
//   x_flat  recovered x[i] at [i*XW +: XW], held until the next start
//   err     sticky per-run error flag, valid with done
//
// Optional feature: define DECONV_ERR_EN to drive err. Without it err is
// tied low and the remainder check is removed; clamping is unchanged.
module deconv_seq #(
  parameter int YW = 12,
  parameter int XW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [8*YW-1:0] y_flat,
  input  logic [8*XW-1:0] h_flat,
  output logic            busy,
  output logic            done,
  output logic [8*XW-1:0] x_flat,
  output logic            err
);

  localparam int RW = YW + 2;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DIV, DONE} state_t;

  state_t state, state_next;

  logic [7:0][YW-1:0] y_reg;
  logic [7:0][XW-1:0] h_reg;
  logic [7:0][XW-1:0] x_reg;
  logic [2:0]         n;
  logic [2:0]         k;
  logic [1:0]         dcnt;
  logic signed [RW-1:0] res;
  logic [XW-1:0]      q;
  logic               neg_f;
  logic               ovf_f;

  // Multiply-accumulate operands: products are unsigned and zero-extended
  // before they are subtracted from the signed residue.
  logic [2:0]           xi;
  logic [2*XW-1:0]      prod;
  logic signed [RW-1:0] prod_ext;

  assign xi       = n - k;
  assign prod     = h_reg[k] * x_reg[xi];
  assign prod_ext = signed'({{(RW-2*XW){1'b0}}, prod});

  // Restoring divider: step counts down 3..0 so quotient bits come MSB first.
  logic signed [RW-1:0] h0_ext;
  logic signed [RW-1:0] limit;
  logic signed [RW-1:0] dsh;
  logic signed [RW-1:0] trial;
  logic [1:0]           step;
  logic                 trial_ok;
  logic [XW-1:0]        mask;
  logic [XW-1:0]        q_next;
  logic                 neg_now;
  logic                 ovf_now;
  logic [XW-1:0]        x_new;

  assign h0_ext   = signed'({{(RW-XW){1'b0}}, h_reg[0]});
  assign limit    = h0_ext << 4;
  assign step     = 2'd3 - dcnt;
  assign dsh      = h0_ext << step;
  assign trial    = res - dsh;
  assign trial_ok = ~trial[RW-1];
  assign mask     = {{(XW-1){1'b0}}, 1'b1} << step;
  assign q_next   = trial_ok ? (q | mask) : q;

  // Range flags are judged on the residue as it enters the divider; later
  // divide cycles use the registered copies because res is being reduced.
  assign neg_now = (dcnt == 2'd0) ? res[RW-1] : neg_f;
  assign ovf_now = (dcnt == 2'd0) ? (res >= limit) : ovf_f;
  assign x_new   = neg_now ? '0 : (ovf_now ? {XW{1'b1}} : q_next);

`ifdef DECONV_ERR_EN
  logic                 err_q;
  logic signed [RW-1:0] rem_fin;
  logic                 inexact;

  assign rem_fin = trial_ok ? trial : res;
  assign inexact = (rem_fin != '0);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. A zero h[0] is caught in the first LOAD so the
  // shortcut run still reports done one edge after the acceptance edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (n == 3'd0 && h_reg[0] == '0) state_next = DONE;
        else if (n != 3'd0)              state_next = MAC;
        else                             state_next = DIV;
      end
      MAC:  if (k == n) state_next = DIV;
      DIV: begin
        if (dcnt == 2'd3) state_next = (n == 3'd7) ? DONE : LOAD;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, residue accumulation, division and x write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg <= '0;
      h_reg <= '0;
      x_reg <= '0;
      n     <= '0;
      k     <= '0;
      dcnt  <= '0;
      res   <= '0;
      q     <= '0;
      neg_f <= 1'b0;
      ovf_f <= 1'b0;
`ifdef DECONV_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            y_reg <= y_flat;
            h_reg <= h_flat;
            x_reg <= '0;
            n     <= '0;
`ifdef DECONV_ERR_EN
            err_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          res  <= signed'({2'b00, y_reg[n]});
          k    <= 3'd1;
          dcnt <= '0;
          q    <= '0;
`ifdef DECONV_ERR_EN
          if (n == 3'd0 && h_reg[0] == '0) err_q <= 1'b1;
`endif
        end
        MAC: begin
          res <= res - prod_ext;
          k   <= k + 3'd1;
        end
        DIV: begin
          if (trial_ok) res <= trial;
          q    <= q_next;
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd0) begin
            neg_f <= neg_now;
            ovf_f <= ovf_now;
          end
          if (dcnt == 2'd3) begin
            x_reg[n] <= x_new;
            if (n != 3'd7) n <= n + 3'd1;
`ifdef DECONV_ERR_EN
            if (neg_now || ovf_now || inexact) err_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == LOAD) || (state == MAC) || (state == DIV);
  assign done   = (state == DONE);
  assign x_flat = x_reg;

endmodule
